// File: rtl/mult_pkg.sv
// Shared constants and state encoding for the iterative MIPS mult/multu engine.
package mult_pkg;

  localparam int unsigned MULT_WIDTH   = 32;
  localparam int unsigned MULT_CNT_W   = $clog2(MULT_WIDTH);
  localparam int unsigned MULT_LATENCY = MULT_WIDTH + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } mult_state_e;

endpackage

// File: rtl/mult_unit.sv
// Sequential shift-add multiplier for mult/multu, one multiplier bit per cycle.
// Optional `MULT_EARLY_TERM_EN leaves CALC once the remaining multiplier bits are zero.
module mult_unit
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = MULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);
`ifdef MULT_EARLY_TERM_EN
  localparam bit EARLY_TERM = 1'b1;
`else
  localparam bit EARLY_TERM = 1'b0;
`endif

  mult_state_e      state_q, state_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] mag_a_c, mag_b_c;
  logic [PW-1:0]    result_c;
  logic             last_iter_c;
  logic             launch_c;

  // Operand magnitudes (raw for multu); final sign fix is modulo 2^PW.
  always_comb begin
    mag_a_c     = (signed_op && data_a[WIDTH-1]) ? (~data_a + WIDTH'(1)) : data_a;
    mag_b_c     = (signed_op && data_b[WIDTH-1]) ? (~data_b + WIDTH'(1)) : data_b;
    result_c    = neg_q ? ((~acc_q) + PW'(1)) : acc_q;
    last_iter_c = (cnt_q == CW'(WIDTH - 1)) ||
                  (EARLY_TERM && (mplier_q[WIDTH-1:1] == '0));
    launch_c    = ((state_q == IDLE) || (state_q == DONE)) && start;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (last_iter_c) state_d = SIGN;
      SIGN:    state_d = DONE;
      DONE:    state_d = start ? CALC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status flags are registered from the next state so they line up with it.
  always_comb begin
    busy_d = (state_d == CALC) || (state_d == SIGN);
    done_d = (state_d == DONE);
  end

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    if (launch_c) begin
      mcand_d  = {{WIDTH{1'b0}}, mag_a_c};
      mplier_d = mag_b_c;
      acc_d    = '0;
      cnt_d    = '0;
      neg_d    = signed_op & (data_a[WIDTH-1] ^ data_b[WIDTH-1]);
    end else if (state_q == CALC) begin
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
    end else if (state_q == SIGN) begin
      acc_d = result_c;
      hi_d  = result_c[PW-1:WIDTH];
      lo_d  = result_c[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign hi_out = hi_q;
  assign lo_out = lo_q;

endmodule
